// File: rtl/counter_pkg.sv
// Shared constants, FSM state encoding and a power-of-ten helper for the BCD encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_pkg;

    // Default binary width, matching the upstream up/down counter output
    localparam int DEF_WIDTH = 4;
    // Bits per BCD digit
    localparam int BCD_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // 10^d, used at elaboration to check that D digits can hold 2^N-1
    function automatic longint unsigned pow10(input int d);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < d; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_bcd_encoder_if.sv
// Request/result bundle between a binary counter source and the BCD encoder.
// Latency: n/a (wires only).
// Backpressure: none; the source watches busy/done and re-requests as needed.
interface counter_bcd_encoder_if
    import counter_pkg::*;
#(
    parameter int N = DEF_WIDTH,
    parameter int D = 2
);
    logic [N-1:0]       bin_in;
    logic               start;
    logic [BCD_W*D-1:0] bcd_out;
    logic               busy;
    logic               done;

    modport master (output bin_in, start, input bcd_out, busy, done);
    modport slave  (input bin_in, start, output bcd_out, busy, done);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_add3
    import counter_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/counter_bcd_encoder.sv
// Binary-to-BCD encoder (shift-and-add-3); optional BCD_CHANGE_DETECT_EN auto-starts on a new input value.
// Latency: N+1 cycles from the start-sampling edge to the done pulse.
// Backpressure: start is ignored (not queued) while busy or finishing; bcd_out holds until the next result.
module counter_bcd_encoder
    import counter_pkg::*;
#(
    parameter int N = DEF_WIDTH,
    parameter int D = 2
)
(
    input logic                   clk,
    input logic                   clear,
    counter_bcd_encoder_if.slave  bus
);
    localparam int W  = BCD_W * D;
    localparam int CW = $clog2(N + 1);

    // D digits must be able to represent the largest N-bit value
    if (pow10(D) <= ((64'd1 << N) - 64'd1)) begin : g_bad_digits
        $error("counter_bcd_encoder: D=%0d digits cannot hold 2^%0d-1", D, N);
    end

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    bin_sh;
    logic [W-1:0]    bcd_wk;
    logic [W-1:0]    bcd_adj;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    bcd_q;
    logic            done_q;
    logic            busy;
    logic            go;

`ifdef BCD_CHANGE_DETECT_EN
    logic [N-1:0]    last_bin;
    assign go = bus.start | (bus.bin_in != last_bin);
`else
    assign go = bus.start;
`endif

    // One correction cell per working digit
    for (genvar g = 0; g < D; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd_wk[g*BCD_W +: BCD_W]),
            .dout (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    // State register; clear wins over everything and aborts a conversion
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one SHIFT per input bit, then one FINISH cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: busy tracks the shifting phase only
    always_comb begin
        busy = 1'b0;
        if (state == SHIFT) busy = 1'b1;
    end

    // Datapath: capture, adjust-then-shift, publish the result on leaving FINISH
    always_ff @(posedge clk) begin
        if (clear) begin
            bin_sh   <= '0;
            bcd_wk   <= '0;
            cnt      <= '0;
            bcd_q    <= '0;
            done_q   <= 1'b0;
`ifdef BCD_CHANGE_DETECT_EN
            last_bin <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        bin_sh   <= bus.bin_in;
                        bcd_wk   <= '0;
                        cnt      <= CW'(N);
`ifdef BCD_CHANGE_DETECT_EN
                        last_bin <= bus.bin_in;
`endif
                    end
                end
                SHIFT: begin
                    {bcd_wk, bin_sh} <= {bcd_adj[W-2:0], bin_sh, 1'b0};
                    cnt              <= cnt - CW'(1);
                end
                FINISH: begin
                    bcd_q  <= bcd_wk;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.bcd_out = bcd_q;
    assign bus.busy    = busy;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_counter_bcd_encoder.sv
// Directed bench for counter_bcd_encoder: N=4/D=2 and N=8/D=3 instances on one clock.
// Latency: checks the N+1 cycle start-to-done delay.
// Backpressure: checks that start is dropped while busy and that clear aborts.
module tb_counter_bcd_encoder;

    logic clk;
    logic clear;
    int   n_checks;
    int   n_err;

    counter_bcd_encoder_if #(.N(4), .D(2)) bus4 ();
    counter_bcd_encoder_if #(.N(8), .D(3)) bus8 ();

    counter_bcd_encoder #(.N(4), .D(2)) dut4 (
        .clk   (clk),
        .clear (clear),
        .bus   (bus4.slave)
    );

    counter_bcd_encoder #(.N(8), .D(3)) dut8 (
        .clk   (clk),
        .clear (clear),
        .bus   (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles after the start edge until done, -1 if it never comes
    task automatic wait_done(input bit wide, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if ((wide ? bus8.done : bus4.done) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic conv4(input logic [3:0] v, output int lat);
        bus4.bin_in = v;
        bus4.start  = 1'b1;
        tick();
        bus4.start  = 1'b0;
        wait_done(1'b0, lat);
    endtask

    task automatic conv8(input logic [7:0] v, output int lat);
        bus8.bin_in = v;
        bus8.start  = 1'b1;
        tick();
        bus8.start  = 1'b0;
        wait_done(1'b1, lat);
    endtask

    logic [3:0]  tab_in  [3] = '{4'd7, 4'd10, 4'd13};
    logic [7:0]  tab_exp [3] = '{8'h07, 8'h10, 8'h13};

    initial begin
        int   lat;
        int   ndone;
        logic all_busy;

        n_checks    = 0;
        n_err       = 0;
        clear       = 1'b1;
        bus4.bin_in = '0;
        bus4.start  = 1'b0;
        bus8.bin_in = '0;
        bus8.start  = 1'b0;
        tick();
        tick();
        clear = 1'b0;

        // Reset state
        chk("rst_busy4", 32'(bus4.busy), 32'd0);
        chk("rst_done4", 32'(bus4.done), 32'd0);
        chk("rst_bcd4",  32'(bus4.bcd_out), 32'h00);
        chk("rst_busy8", 32'(bus8.busy), 32'd0);
        chk("rst_bcd8",  32'(bus8.bcd_out), 32'h000);

        // Convert zero
        bus4.bin_in = 4'd0;
        bus4.start  = 1'b1;
        tick();
        bus4.start  = 1'b0;
        chk("zero_busy", 32'(bus4.busy), 32'd1);
        wait_done(1'b0, lat);
        chk("zero_lat", 32'(lat), 32'd5);
        chk("zero_bcd", 32'(bus4.bcd_out), 32'h00);
        tick();

        // Maximum 4-bit value, cycle by cycle
        bus4.bin_in = 4'd15;
        bus4.start  = 1'b1;
        tick();
        bus4.start  = 1'b0;
        all_busy    = bus4.busy;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e <= 3) all_busy = all_busy & bus4.busy;
            if (e == 4) begin
                chk("max_all_busy",  32'(all_busy), 32'd1);
                chk("max_fin_busy",  32'(bus4.busy), 32'd0);
                chk("max_fin_done",  32'(bus4.done), 32'd0);
                chk("max_fin_hold",  32'(bus4.bcd_out), 32'h00);
            end
            if (e == 5) begin
                chk("max_done", 32'(bus4.done), 32'd1);
                chk("max_bcd",  32'(bus4.bcd_out), 32'h15);
            end
        end
        tick();
        chk("max_done_fall", 32'(bus4.done), 32'd0);
        chk("max_bcd_hold",  32'(bus4.bcd_out), 32'h15);

        // Start while busy is dropped; input change after capture is ignored
        bus4.bin_in = 4'd9;
        bus4.start  = 1'b1;
        tick();
        bus4.start  = 1'b0;
        tick();
        bus4.bin_in = 4'd3;
        bus4.start  = 1'b1;
        tick();
        bus4.start  = 1'b0;
        bus4.bin_in = 4'd9;
        chk("busy_bcd_hold", 32'(bus4.bcd_out), 32'h15);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus4.done === 1'b1) ndone++;
        end
        chk("busy_ndone", 32'(ndone), 32'd1);
        chk("busy_bcd",   32'(bus4.bcd_out), 32'h09);

        // Clear mid-conversion
        bus4.bin_in = 4'd12;
        bus4.start  = 1'b1;
        tick();
        bus4.start  = 1'b0;
        tick();
        tick();
        clear       = 1'b1;
        bus4.bin_in = 4'd0;
        tick();
        clear = 1'b0;
        chk("abort_busy", 32'(bus4.busy), 32'd0);
        chk("abort_bcd",  32'(bus4.bcd_out), 32'h00);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus4.done === 1'b1) ndone++;
        end
        chk("abort_ndone", 32'(ndone), 32'd0);

        // Clear and start together stay idle
        clear       = 1'b1;
        bus4.start  = 1'b1;
        bus4.bin_in = 4'd5;
        tick();
        clear       = 1'b0;
        bus4.start  = 1'b0;
        bus4.bin_in = 4'd0;
        chk("clr_start_busy", 32'(bus4.busy), 32'd0);
        tick();
        chk("clr_start_busy2", 32'(bus4.busy), 32'd0);

        // Assorted 4-bit values
        for (int k = 0; k < 3; k++) begin
            conv4(tab_in[k], lat);
            chk($sformatf("tab_lat_%0d", tab_in[k]), 32'(lat), 32'd5);
            chk($sformatf("tab_bcd_%0d", tab_in[k]), 32'(bus4.bcd_out), 32'(tab_exp[k]));
            tick();
        end

        // Wide instance
        conv8(8'd255, lat);
        chk("wide255_lat", 32'(lat), 32'd9);
        chk("wide255_bcd", 32'(bus8.bcd_out), 32'h255);
        tick();
        conv8(8'd100, lat);
        chk("wide100_lat", 32'(lat), 32'd9);
        chk("wide100_bcd", 32'(bus8.bcd_out), 32'h100);
        tick();
        conv8(8'd99, lat);
        chk("wide99_bcd", 32'(bus8.bcd_out), 32'h099);
        tick();

        // Counter steps 7 -> 8 without a start pulse
        conv4(4'd7, lat);
        chk("cd_pre_bcd", 32'(bus4.bcd_out), 32'h07);
        tick();
        bus4.bin_in = 4'd8;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus4.done === 1'b1) ndone++;
        end
`ifdef BCD_CHANGE_DETECT_EN
        chk("cd_ndone", 32'(ndone), 32'd1);
        chk("cd_bcd",   32'(bus4.bcd_out), 32'h08);
`else
        chk("cd_ndone", 32'(ndone), 32'd0);
        chk("cd_bcd",   32'(bus4.bcd_out), 32'h07);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
